// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the bit-shift PE datapath.
package pe_pkg;
    localparam int PE_OUT_W    = 19;
    localparam int PE_ACC_W    = 24;
    localparam int KERNEL_TAPS = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/pe_sat_add.sv
// Combinational two's-complement adder that clips to the W-bit range
// and flags when clipping happened.
module pe_sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W-1:0] raw;

    assign raw = a + b;
    // Overflow only when both operands share a sign that the result lost.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    assign sum = !ovf ? raw :
                 a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
endmodule

// File: rtl/pe_accumulator.sv
// Sums TAPS signed PE products into one saturated partial sum and hands it
// downstream over valid/ready. Define PE_ACC_RELU_EN to clamp negative results to 0.
//
// Handshake: a product moves on a rising edge where i_valid && o_ready && !i_clear;
// a result moves on a rising edge where o_valid && i_ready. o_ready depends only on
// registered state, never on i_valid or i_ready.
module pe_accumulator
    import pe_pkg::*;
#(
    parameter int IN_W  = PE_OUT_W,
    parameter int ACC_W = PE_ACC_W,
    parameter int TAPS  = KERNEL_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_calculated,
    output logic             o_ready,
    input  logic             i_clear,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_sat,
    output logic [1:0]       dbg_state
);
    localparam int CNT_W = 8;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sticky;

    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [ACC_W-1:0] final_sum;
    logic             accept;
    logic             last;

    assign in_ext    = {{(ACC_W-IN_W){i_calculated[IN_W-1]}}, i_calculated};
    assign o_ready   = (state != HOLD);
    assign accept    = i_valid && o_ready && !i_clear;
    assign last      = (cnt == CNT_W'(TAPS - 1));
    assign dbg_state = state;

    // acc is held at zero outside ACCUM, so the first product lands unchanged.
    pe_sat_add #(.W(ACC_W)) u_add (
        .a   (acc),
        .b   (in_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

`ifdef PE_ACC_RELU_EN
    assign final_sum = add_sum[ACC_W-1] ? '0 : add_sum;
`else
    assign final_sum = add_sum;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (i_clear) begin
                        state  <= IDLE;
                        acc    <= '0;
                        cnt    <= '0;
                        sticky <= 1'b0;
                    end else if (accept) begin
                        if (last) begin
                            o_sum   <= final_sum;
                            o_sat   <= sticky | add_ovf;
                            o_valid <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            acc    <= add_sum;
                            cnt    <= cnt + 8'd1;
                            sticky <= sticky | add_ovf;
                            state  <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (i_clear || i_ready) begin
                        state   <= IDLE;
                        acc     <= '0;
                        cnt     <= '0;
                        sticky  <= 1'b0;
                        o_valid <= 1'b0;
                    end
                    // A flush throws the result away rather than leaving it on the bus.
                    if (i_clear) begin
                        o_sum <= '0;
                        o_sat <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
